nn_mul_share_arb: RTL and testbench

- Round-robin arbiter/scheduler that time-shares one unsigned 8b x 9b -> 16b multiplier among NUM_REQ requesters.
- Sits between convolution/FC lane controllers and a single multiplier resource in the AlexNet datapath, saving DSPs on low-duty-cycle lanes.
- Valid/ready handshake on every requester and on the shared result port.
- One registered output stage with the requester ID tagged on each result.

---
 rtl/nn_mul_share_arb.sv | 200 ++++++++++++++++++++
 tb/tb_nn_mul_share_arb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_mul_share_arb.sv
// nn_mul_share_arb
// ----------------
// Round-robin scheduler that time-shares a single unsigned
// DIN0_W x DIN1_W multiplier among NUM_REQ requesters. Each accepted
// operand pair produces one result, truncated to DOUT_W bits. The result
// is held in a single registered output stage and tagged with the index
// of the requester that produced it.
//
// Ports
//   ap_clk     in   clock, rising edge
//   ap_rst     in   synchronous reset, active-high
//   req_valid  in   [NUM_REQ]         per-requester operand valid
//   req_ready  out  [NUM_REQ]         per-requester accept (one-hot or zero)
//   req_din0   in   [NUM_REQ*DIN0_W]  operand 0, requester i at [i*DIN0_W +: DIN0_W]
//   req_din1   in   [NUM_REQ*DIN1_W]  operand 1, packed the same way
//   rsp_valid  out  result valid
//   rsp_ready  in   downstream accepts the result
//   rsp_dout   out  [DOUT_W]  product, low DOUT_W bits
//   rsp_id     out  [ID_W]    index of the requester that produced rsp_dout
//
// Optional build macro NN_MUL_ARB_STATS_EN adds:
//   grant_cnt  out  [NUM_REQ*16]  per-requester saturating accept counters
//   stall_cnt  out  [16]          saturating count of FULL & !rsp_ready cycles
module nn_mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DIN0_W  = 8,
  parameter int DIN1_W  = 9,
  parameter int DOUT_W  = 16
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DIN0_W-1:0] req_din0,
  input  logic [NUM_REQ*DIN1_W-1:0] req_din1,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DOUT_W-1:0]         rsp_dout,
  output logic [ID_W-1:0]           rsp_id
`ifdef NN_MUL_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     grant_cnt,
  output logic [15:0]               stall_cnt
`endif
);

  localparam int PROD_W = DIN0_W + DIN1_W;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DOUT_W-1:0] r_dout, w_dout_nxt;
  logic [ID_W-1:0]   r_id, w_id_nxt;
  logic [ID_W-1:0]   r_last, w_last_nxt;

  logic              w_adv;
  logic              w_found;
  logic              w_fire;
  logic [ID_W-1:0]   w_win;
  logic [ID_W-1:0]   w_idx;
  logic [DIN0_W-1:0] w_op0;
  logic [DIN1_W-1:0] w_op1;
  logic [DOUT_W-1:0] w_prod;

  // Unsigned zero-extended product, truncated to the result width.
  function automatic logic [DOUT_W-1:0] mul_trunc(input logic [DIN0_W-1:0] a,
                                                  input logic [DIN1_W-1:0] b);
    logic [PROD_W-1:0] p;
    p = PROD_W'(a) * PROD_W'(b);
    return p[DOUT_W-1:0];
  endfunction

  // Round-robin scan starting one past the last winner; pick the winner's operands.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end else begin
        w_found = w_found;
      end
    end
    w_op0 = '0;
    w_op1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == ID_W'(i)) begin
        w_op0 = req_din0[i*DIN0_W +: DIN0_W];
        w_op1 = req_din1[i*DIN1_W +: DIN1_W];
      end else begin
        w_op0 = w_op0;
      end
    end
  end

  assign w_prod = mul_trunc(w_op0, w_op1);

  // The output slot can take new data when empty or when it drains this cycle.
  assign w_adv  = (r_state == ST_EMPTY) | rsp_ready;
  assign w_fire = w_found & w_adv & ~ap_rst;

  // One-hot accept to the winner; all zero during reset, backpressure or no winner.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_fire && (w_win == ID_W'(i))) begin
        req_ready[i] = 1'b1;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Output-stage next state: load on accept, drain to EMPTY when consumed without refill.
  always_comb begin
    w_state_nxt = r_state;
    w_dout_nxt  = r_dout;
    w_id_nxt    = r_id;
    w_last_nxt  = r_last;
    case (r_state)
      ST_EMPTY: begin
        if (w_fire) begin
          w_state_nxt = ST_FULL;
          w_dout_nxt  = w_prod;
          w_id_nxt    = w_win;
          w_last_nxt  = w_win;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_fire) begin
          w_state_nxt = ST_FULL;
          w_dout_nxt  = w_prod;
          w_id_nxt    = w_win;
          w_last_nxt  = w_win;
        end else if (rsp_ready) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // State and output registers; reset points the RR pointer so requester 0 goes first.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= ST_EMPTY;
      r_dout  <= '0;
      r_id    <= '0;
      r_last  <= ID_W'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_dout  <= w_dout_nxt;
      r_id    <= w_id_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_dout  = r_dout;
  assign rsp_id    = r_id;

`ifdef NN_MUL_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] r_grant_cnt;
  logic [15:0]           r_stall_cnt;

  // Saturating accept and stall counters.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_grant_cnt <= '0;
      r_stall_cnt <= 16'd0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && (r_grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
          r_grant_cnt[i*16 +: 16] <= r_grant_cnt[i*16 +: 16] + 16'd1;
        end
      end
      if ((r_state == ST_FULL) && !rsp_ready && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign grant_cnt = r_grant_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_nn_mul_share_arb.sv
// Randomized scoreboard bench for nn_mul_share_arb. A reference model
// applies the round-robin rule to the driven requests and queues the
// expected {id, product}; a separate monitor pops and compares whenever
// the DUT presents a result.
module tb_nn_mul_share_arb;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DIN0_W  = 8;
  localparam int DIN1_W  = 9;
  localparam int DOUT_W  = 16;

  logic                      ap_clk;
  logic                      ap_rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DIN0_W-1:0] req_din0;
  logic [NUM_REQ*DIN1_W-1:0] req_din1;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DOUT_W-1:0]         rsp_dout;
  logic [ID_W-1:0]           rsp_id;
`ifdef NN_MUL_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]     grant_cnt;
  logic [15:0]               stall_cnt;
`endif

  nn_mul_share_arb #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .DIN0_W(DIN0_W), .DIN1_W(DIN1_W), .DOUT_W(DOUT_W)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_din0 (req_din0),
    .req_din1 (req_din1),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dout (rsp_dout),
    .rsp_id   (rsp_id)
`ifdef NN_MUL_ARB_STATS_EN
    ,
    .grant_cnt(grant_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    int id;
    int dout;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  bit   m_full = 1'b0;
  int   m_last = NUM_REQ - 1;
  int   m_gcnt[NUM_REQ];
  int   m_stall = 0;

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: decides the accept for the coming edge from the spec's rules.
  always @(negedge ap_clk) begin
    int   win;
    bit   adv;
    logic [NUM_REQ-1:0] exp_rdy;
    rsp_t e;
    #2;
    if (ap_rst) begin
      chk("req_ready_in_reset", req_ready, 0);
      m_full = 1'b0;
      m_last = NUM_REQ - 1;
      exp_q.delete();
      foreach (m_gcnt[i]) m_gcnt[i] = 0;
      m_stall = 0;
    end else begin
      adv = !m_full || rsp_ready;
      win = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int idx;
        idx = (m_last + k) % NUM_REQ;
        if (win < 0 && req_valid[idx]) win = idx;
      end
      exp_rdy = '0;
      if (win >= 0 && adv) exp_rdy[win] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      if (m_full && !rsp_ready && m_stall < 65535) m_stall++;
      if (exp_rdy != '0) begin
        e.id   = win;
        e.dout = (int'(req_din0[win*DIN0_W +: DIN0_W]) * int'(req_din1[win*DIN1_W +: DIN1_W])) % 65536;
        exp_q.push_back(e);
        m_last = win;
        m_full = 1'b1;
        if (m_gcnt[win] < 65535) m_gcnt[win]++;
      end else if (m_full && rsp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: compares the presented result against the scoreboard head.
  always @(negedge ap_clk) begin
    if (mon_en) begin
      chk("rsp_valid", rsp_valid, m_full);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp_unexpected: got id %0d dout 0x%0h, expected no result", rsp_id, rsp_dout);
        end else begin
          chk("rsp_id", rsp_id, exp_q[0].id);
          chk("rsp_dout", rsp_dout, exp_q[0].dout);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_din0[i*DIN0_W +: DIN0_W] = DIN0_W'($urandom);
      req_din1[i*DIN1_W +: DIN1_W] = DIN1_W'($urandom);
    end
  endtask

  initial begin
    foreach (m_gcnt[i]) m_gcnt[i] = 0;
    ap_rst    = 1'b1;
    req_valid = '0;
    req_din0  = '0;
    req_din1  = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    mon_en = 1'b1;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("reset_rsp_dout", rsp_dout, 0);
    chk("reset_rsp_id", rsp_id, 0);

    // Single request: 3*5 from requester 0.
    step();
    req_valid = 4'b0001;
    req_din0[7:0] = 8'd3;
    req_din1[8:0] = 9'd5;
    rsp_ready = 1'b1;
    step();
    req_valid = 4'b0000;
    step();

    // All requesters valid continuously.
    req_valid = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      rand_ops();
      step();
    end
    req_valid = 4'b0000;
    step();

    // Truncation corner on requester 2.
    req_valid = 4'b0100;
    req_din0[2*DIN0_W +: DIN0_W] = 8'd255;
    req_din1[2*DIN1_W +: DIN1_W] = 9'd511;
    step();
    req_valid = 4'b0000;
    step();

    // Backpressure with requester 1 waiting.
    rand_ops();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0010;
    repeat (3) step();
    rsp_ready = 1'b1;
    step();
    req_valid = 4'b0000;
    step();

    // Reset while FULL with requester 3 pending.
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    step();
    req_valid = 4'b1000;
    step();
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
    req_valid = 4'b1001;
    rsp_ready = 1'b1;
    step();
    req_valid = 4'b1000;
    step();
    req_valid = 4'b0000;
    step();

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 3000; c++) begin
      rand_ops();
      req_valid = NUM_REQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      ap_rst    = ($urandom_range(0, 199) == 0);
      step();
    end

    // Drain.
    ap_rst    = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) step();
    @(negedge ap_clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);
`ifdef NN_MUL_ARB_STATS_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      chk("grant_cnt", grant_cnt[i*16 +: 16], m_gcnt[i]);
    end
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
